// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - single-port ROM shared between instruction fetch and data read
// MEM wins contention unless IF has waited STARVE_MAX grants; data returns one cycle after grant.
module rom_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              stall_pc,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_stall,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACT  = 2'd1,
    MEM_ACT = 2'd2
  } owner_t;

  localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] WORD_MASK  = {{(ADDR_W-2){1'b1}}, 2'b00};

  owner_t     owner;
  owner_t     owner_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;
  logic       grant_if;
  logic       grant_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Everything requester-facing is gated by rst so the ROM is never enabled during reset.
  always_comb begin
    grant_if   = 1'b0;
    grant_mem  = 1'b0;
    owner_nxt  = IDLE;
    starve_nxt = starve_cnt;
    rom_ce     = 1'b0;
    rom_addr   = '0;
    stall_pc   = 1'b0;
    mem_stall  = 1'b0;

    if (!rst) begin
      if (if_req && (!mem_req || starve_cnt >= STARVE_LIM)) begin
        grant_if = 1'b1;
      end else if (mem_req) begin
        grant_mem = 1'b1;
      end

      if (!if_req || grant_if) begin
        starve_nxt = 4'd0;
      end else if (grant_mem && starve_cnt < STARVE_LIM) begin
        starve_nxt = starve_cnt + 4'd1;
      end

      if (grant_if) begin
        owner_nxt = IF_ACT;
        rom_ce    = 1'b1;
        rom_addr  = if_addr & WORD_MASK;
      end else if (grant_mem) begin
        owner_nxt = MEM_ACT;
        rom_ce    = 1'b1;
        rom_addr  = mem_addr & WORD_MASK;
      end

      stall_pc  = if_req & ~grant_if;
      mem_stall = mem_req & ~grant_mem;
    end
  end

  // owner is cleared asynchronously, so an access cut by reset never produces a pulse.
  always_comb begin
    if_valid  = 1'b0;
    if_rdata  = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    case (owner)
      IF_ACT: begin
        if_valid = 1'b1;
        if_rdata = rom_rdata;
      end
      MEM_ACT: begin
        mem_valid = 1'b1;
        mem_rdata = rom_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - self-checking bench for rom_arbiter
// Cycle model compared at every falling edge, plus directed literal checks.
module tb_rom_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          stall_pc;
  logic          mem_req = 1'b0;
  logic [AW-1:0] mem_addr = '0;
  logic          mem_valid;
  logic [DW-1:0] mem_rdata;
  logic          mem_stall;
  logic          rom_ce;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rdata = '0;

  int tests = 0;
  int fails = 0;

  rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .stall_pc(stall_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_rdata(rom_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_wait counts MEM grants while IF waited; m_own is who was granted last edge (0/1=IF/2=MEM).
  int   m_wait = 0;
  int   m_own  = 0;
  int   pend   = 0;
  logic pend_ifreq = 1'b0;

  always @(negedge clk) begin
    logic gi, gm;
    logic [AW-1:0] ea;
    if (rst) begin
      chk("rst_rom_ce", rom_ce, 0);      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_stall_pc", stall_pc, 0);  chk("rst_mem_stall", mem_stall, 0);
      chk("rst_if_valid", if_valid, 0);  chk("rst_mem_valid", mem_valid, 0);
      chk("rst_if_rdata", if_rdata, 0);  chk("rst_mem_rdata", mem_rdata, 0);
      pend = 0;
      pend_ifreq = 1'b0;
    end else begin
      gi = if_req && (!mem_req || m_wait >= SM);
      gm = mem_req && !gi;
      ea = gi ? (if_addr / 4) * 4 : gm ? (mem_addr / 4) * 4 : '0;
      chk("m_rom_ce", rom_ce, gi || gm);
      chk("m_rom_addr", rom_addr, ea);
      chk("m_stall_pc", stall_pc, if_req && !gi);
      chk("m_mem_stall", mem_stall, mem_req && !gm);
      chk("m_if_valid", if_valid, m_own == 1);
      chk("m_if_rdata", if_rdata, (m_own == 1) ? rom_rdata : '0);
      chk("m_mem_valid", mem_valid, m_own == 2);
      chk("m_mem_rdata", mem_rdata, (m_own == 2) ? rom_rdata : '0);
      pend = gi ? 1 : gm ? 2 : 0;
      pend_ifreq = if_req;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_wait = 0;
      m_own  = 0;
    end else begin
      m_own  = pend;
      m_wait = (pend == 2 && pend_ifreq) ? m_wait + 1 : 0;
    end
  end

  task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic mr,
                       input logic [AW-1:0] ma, input logic [DW-1:0] rd);
    @(posedge clk);
    #1;
    if_req = ir; if_addr = ia; mem_req = mr; mem_addr = ma; rom_rdata = rd;
  endtask

  logic [7:0] pat_if;
  logic [7:0] pat_mem;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Fetch-only stream, same address, ROM returns A,B,C
    drive(1, 32'h10, 0, 0, 32'h99);
    @(negedge clk); chk("f1_rom_addr", rom_addr, 32'h10); chk("f1_stall_pc", stall_pc, 0); chk("f1_if_valid", if_valid, 0);
    drive(1, 32'h10, 0, 0, 32'hA);
    @(negedge clk); chk("f2_rom_addr", rom_addr, 32'h10); chk("f2_if_valid", if_valid, 1); chk("f2_if_rdata", if_rdata, 32'hA);
    drive(1, 32'h10, 0, 0, 32'hB);
    @(negedge clk); chk("f3_rom_addr", rom_addr, 32'h10); chk("f3_if_rdata", if_rdata, 32'hB);
    drive(0, 0, 0, 0, 32'hC);
    @(negedge clk); chk("f4_if_valid", if_valid, 1); chk("f4_if_rdata", if_rdata, 32'hC); chk("f4_rom_ce", rom_ce, 0);

    // Unaligned data address
    drive(0, 0, 1, 32'h1237, 0);
    @(negedge clk); chk("al_rom_addr", rom_addr, 32'h1234); chk("al_mem_stall", mem_stall, 0);
    drive(0, 0, 0, 0, 32'hDEAD);
    @(negedge clk); chk("al_mem_valid", mem_valid, 1); chk("al_mem_rdata", mem_rdata, 32'hDEAD); chk("al_if_valid", if_valid, 0);

    // Idle
    for (int i = 0; i < 5; i++) begin
      drive(0, 32'h44, 0, 32'h88, 32'h1234_5678);
      @(negedge clk);
      chk("id_rom_ce", rom_ce, 0); chk("id_rom_addr", rom_addr, 0);
      chk("id_valids", {if_valid, mem_valid}, 0); chk("id_stalls", {stall_pc, mem_stall}, 0);
    end

    // Continuous contention: M,M,M,M,I
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h200, 1, 32'h301, 32'h100 + i);
      @(negedge clk);
      chk("ct_stall_pc", stall_pc, (i % 5) != 4);
      chk("ct_mem_stall", mem_stall, (i % 5) == 4);
      chk("ct_rom_addr", rom_addr, ((i % 5) == 4) ? 32'h200 : 32'h300);
    end

    // Starvation count cleared by a one-cycle if_req drop
    pat_if  = 8'b1111_1011;  // bit i = if_req in step i
    pat_mem = 8'b1000_0000;  // expected mem_stall
    for (int i = 0; i < 8; i++) begin
      drive(pat_if[i], 32'h204, 1, 32'h308, 32'h200 + i);
      @(negedge clk);
      chk("sr_stall_pc", stall_pc, (i == 2 || i == 7) ? 1'b0 : 1'b1);
      chk("sr_mem_stall", mem_stall, pat_mem[i]);
    end

    // Reset lands mid-access
    drive(0, 0, 1, 32'h40, 32'h77);
    @(negedge clk); chk("rs_rom_ce", rom_ce, 1);
    #2 rst = 1'b1;
    #1;
    chk("rs_all_zero", {rom_ce, rom_addr, stall_pc, mem_stall, if_valid, mem_valid, if_rdata, mem_rdata}, 0);
    drive(1, 32'h80, 0, 0, 32'h55);
    rst = 1'b0;
    @(negedge clk);
    chk("rs_no_mem_valid", mem_valid, 0); chk("rs_if_grant", rom_ce, 1);
    chk("rs_rom_addr", rom_addr, 32'h80); chk("rs_stall_pc", stall_pc, 0);
    drive(0, 0, 0, 0, 32'h66);
    @(negedge clk); chk("rs_if_valid", if_valid, 1); chk("rs_if_rdata", if_rdata, 32'h66);

    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address buses.
REQ-002 Parameter DATA_W, default 32, width of all data buses.
REQ-003 Parameter STARVE_MAX, default 4, max consecutive MEM grants while IF waits; legal range 1..15.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 if_req  input  1  instruction-fetch read request from PC stage.
REQ-007 if_addr  input  ADDR_W  fetch byte address.
REQ-008 if_valid  output  1  fetch data valid, single-cycle pulse.
REQ-009 if_rdata  output  DATA_W  fetch data.
REQ-010 stall_pc  output  1  fetch not granted this cycle; PC holds.
REQ-011 mem_req  input  1  data read request from MEM stage.
REQ-012 mem_addr  input  ADDR_W  data byte address.
REQ-013 mem_valid  output  1  data valid, single-cycle pulse.
REQ-014 mem_rdata  output  DATA_W  data read result.
REQ-015 mem_stall  output  1  data request not granted this cycle.
REQ-016 rom_ce  output  1  ROM chip enable.
REQ-017 rom_addr  output  ADDR_W  ROM word address.
REQ-018 rom_rdata  input  DATA_W  ROM data, valid the cycle after rom_ce.

Function
REQ-019 Grant decision SHALL be combinational from if_req, mem_req, starve_cnt; at most one grant per cycle.
REQ-020 Neither request: no grant, rom_ce=0, rom_addr=0.
REQ-021 Single requester: that requester SHALL be granted.
REQ-022 Both requesting: MEM granted, except when starve_cnt==STARVE_MAX, then IF granted.
REQ-023 rom_ce = any grant; rom_addr = granted address with bits [1:0] forced to 0.
REQ-024 stall_pc = if_req & ~grant_if; mem_stall = mem_req & ~grant_mem.
REQ-025 starve_cnt (4 bits) SHALL increment when both request and MEM is granted, clear to 0 when IF is granted or if_req=0, never exceed STARVE_MAX.
REQ-026 State register owner SHALL take IDLE / IF_ACT / MEM_ACT each edge per the grant that cycle (none / IF / MEM).
REQ-027 Latency: grant in cycle N SHALL yield valid pulse in cycle N+1 on the matching port only.
REQ-028 owner==IF_ACT: if_valid=1, if_rdata=rom_rdata; else if_valid=0, if_rdata=0.
REQ-029 owner==MEM_ACT: mem_valid=1, mem_rdata=rom_rdata; else mem_valid=0, mem_rdata=0.
REQ-030 Back-to-back grants SHALL be supported every cycle with no bubble; owner switches IF<->MEM in one cycle.
REQ-031 Requesters SHALL hold req and addr stable while their stall is 1; the arbiter SHALL NOT latch addresses.
REQ-032 If STARVE_MAX IF grant coincides with mem_req, mem_stall=1 that cycle and starve_cnt clears.

Reset
REQ-033 While rst=1: owner=IDLE, starve_cnt=0, and rom_ce, rom_addr, stall_pc, mem_stall, if_valid, mem_valid, both rdata outputs SHALL be 0 (grants gated by rst).
REQ-034 rst asserted with an access outstanding SHALL suppress its valid pulse; first grant allowed in the first cycle with rst=0.

Verification
REQ-035 Fetch only: if_req=1, if_addr=0x10 for 3 cycles, rom returns 0xA,0xB,0xC -> rom_addr 0x10 each cycle, stall_pc=0, if_valid 1 in cycles 2-4 with if_rdata 0xA,0xB,0xC.
REQ-036 Contention: if_req=mem_req=1 continuously, STARVE_MAX=4 -> grant pattern M,M,M,M,I repeating; stall_pc=1 on M cycles, mem_stall=1 on I cycles.
REQ-037 Alignment: mem_req=1, mem_addr=0x1237 -> rom_addr=0x1234, mem_valid next cycle, if_valid=0.
REQ-038 Starve reset: both request 2 cycles, if_req drops 1 cycle, both request again -> starve_cnt 1,2,0,1; IF not forced before 4 further MEM grants.
REQ-039 Reset mid-access: MEM granted cycle N, rst pulses asynchronously mid cycle N -> no mem_valid in N+1, all outputs 0 during rst, if_req granted first cycle after release.
REQ-040 Idle: no requests 5 cycles -> rom_ce=0, rom_addr=0, all valid/stall outputs 0.
